// File: rtl/nes_pad_reader.sv
// NES serial pad reader: drives latch/pulse, shifts in eight active-low buttons,
// and publishes a registered snapshot with one-cycle pressed/released masks.
module nes_pad_reader #(
    parameter int HALF_BIT = 150
) (
    input  logic       clk25,
    input  logic       reset,
    input  logic       poll_req,
    input  logic       nes_data,
    output logic       nes_latch,
    output logic       nes_pulse,
    output logic [7:0] buttons,
    output logic [7:0] pressed,
    output logic [7:0] released,
    output logic       valid,
    output logic       busy
);

    localparam int CW = $clog2(2 * HALF_BIT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATCH,
        S_WAIT_LO,
        S_PULSE_HI
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [6:0]    r_shift;
    logic          r_latch;
    logic          r_pulse;
    logic          r_busy;
    logic          r_valid;
    logic [7:0]    r_buttons;
    logic [7:0]    r_pressed;
    logic [7:0]    r_released;

    logic          w_last_latch;
    logic          w_last_half;
    logic          w_publish;
    logic [7:0]    w_new;

    always_comb begin
        w_last_latch = (r_cnt == CW'(2 * HALF_BIT - 1));
        w_last_half  = (r_cnt == CW'(HALF_BIT - 1));
        w_publish    = (r_state == S_WAIT_LO) && w_last_half && (r_idx == 3'd7);
        // Final bit bypasses the shift register so publish happens on the sample edge.
        w_new        = {~nes_data, r_shift};
        w_next       = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (poll_req) w_next = S_LATCH;
            end
            S_LATCH: begin
                if (w_last_latch) w_next = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (w_last_half) begin
                    w_next = (r_idx == 3'd7) ? S_IDLE : S_PULSE_HI;
                end
            end
            S_PULSE_HI: begin
                if (w_last_half) w_next = S_WAIT_LO;
            end
        endcase
    end

    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 7'd0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state || r_state == S_IDLE) r_cnt <= '0;
            else r_cnt <= r_cnt + CW'(1);
            if (r_state == S_LATCH && w_last_latch) r_idx <= 3'd0;
            if (r_state == S_PULSE_HI && w_last_half) r_idx <= r_idx + 3'd1;
            if (r_state == S_WAIT_LO && w_last_half && r_idx != 3'd7) begin
                r_shift[r_idx] <= ~nes_data;
            end
        end
    end

    // Pad-facing strobes are registered from the next state so they track it exactly.
    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            r_latch    <= 1'b0;
            r_pulse    <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_buttons  <= 8'd0;
            r_pressed  <= 8'd0;
            r_released <= 8'd0;
        end else begin
            r_latch    <= (w_next == S_LATCH);
            r_pulse    <= (w_next == S_PULSE_HI);
            r_busy     <= (w_next != S_IDLE);
            r_valid    <= w_publish;
            r_pressed  <= w_publish ? (w_new & ~r_buttons) : 8'd0;
            r_released <= w_publish ? (~w_new & r_buttons) : 8'd0;
            if (w_publish) r_buttons <= w_new;
        end
    end

    assign nes_latch = r_latch;
    assign nes_pulse = r_pulse;
    assign busy      = r_busy;
    assign valid     = r_valid;
    assign buttons   = r_buttons;
    assign pressed   = r_pressed;
    assign released  = r_released;

endmodule

// File: doc/nes_pad_reader.md
Name: nes_pad_reader

Overview:
- Host-side reader for the NES-style serial game controller. It produces the 8-bit `buttons` bus consumed by the homescreen, settings and colour FSMs.
- Drives the pad's latch and clock lines and shifts in the serial data line. Results are published as a registered button snapshot plus one-cycle pressed/released edge masks.
- Polls once per `poll_req` pulse. Intended hookup is `screenEnd`, giving one poll per frame.

Parameters:
- HALF_BIT, default 150: pulse high/low phase length in clk25 cycles (6 us at 25 MHz). Legal range 2..1023.

Ports:
- clk25, input, 1: 25 MHz pixel/logic clock; all state on its rising edge.
- reset, input, 1: asynchronous, active-low reset (0 = in reset).
- poll_req, input, 1: start a read; sampled only in IDLE.
- nes_data, input, 1: pad serial data, active-low (0 = pressed), externally pulled up.
- nes_latch, output, 1: pad latch strobe, active-high.
- nes_pulse, output, 1: pad shift clock, active-high.
- buttons, output, 8: current snapshot, 1 = pressed. Bit mapping: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right.
- pressed, output, 8: bits that went 0->1 in this update.
- released, output, 8: bits that went 1->0 in this update.
- valid, output, 1: one-cycle strobe; buttons/pressed/released updated this cycle.
- busy, output, 1: high whenever state != IDLE.

Behaviour:
- Reset values (asynchronous, while reset=0):
  - state=IDLE; nes_latch=0, nes_pulse=0.
  - buttons=0, pressed=0, released=0, valid=0, busy=0.
  - Shift register, bit index and phase counter all 0.
- Registered outputs: every output is registered; none depends combinationally on an input.
- States:
  - IDLE → LATCH, when poll_req=1. The phase counter clears.
  - LATCH: nes_latch=1 for exactly 2*HALF_BIT cycles → WAIT_LO with bit index 0.
  - WAIT_LO: nes_pulse=0 for HALF_BIT cycles.
    - On the last cycle, shift[idx] <= ~nes_data.
    - If idx<7 → PULSE_HI.
    - If idx=7 → IDLE and publish.
  - PULSE_HI: nes_pulse=1 for HALF_BIT cycles, then idx <= idx+1 → WAIT_LO.
- Timing, counting the first nes_latch-high cycle as cycle 1:
  - nes_latch is high in cycles 1..2H, where H = HALF_BIT.
  - Bit i is sampled at the end of cycle 3H + 2H*i, for i=0..7.
  - nes_pulse is high in cycles 3H+1+2H*(i-1) .. 3H+2H*i-H+... i.e. exactly H cycles, starting right after each sample for bits 0..6. There are 7 rising edges in total.
  - Outputs publish so that valid=1 in cycle 17H+1 only. busy=0 in that same cycle.
  - Latency from the poll_req sampling edge to valid: 17H+1 cycles.
- Publish:
  - buttons <= new snapshot, where bit 7 is the final sample, taken directly from nes_data rather than from the shift register.
  - pressed <= new & ~old; released <= ~new & old.
  - pressed/released are cleared to 0 on the next cycle (they are valid-qualified strobes). buttons holds until the next publish.
- Polling rules:
  - poll_req while busy=1 is ignored; it is not queued.
  - poll_req high in the valid cycle is accepted, since the state is already IDLE. The next latch starts the following cycle.
  - poll_req held high continuously gives back-to-back reads.
- Idle outputs: nes_latch and nes_pulse are never both high. Both are 0 in IDLE.
- Disconnected pad: the pull-up reads all 1s, so buttons=0x00. No error is flagged.
- Reset mid-read: all state aborts immediately. buttons returns to 0, with no partial publish. After release the block waits in IDLE for the next poll_req.
- Counters:
  - Phase counter width is clog2(2*HALF_BIT)+1. It wraps to 0 on each state change.
  - Bit index is 3 bits and never exceeds 7.

Test Plan:
- Reset/idle: HALF_BIT=4, hold reset=0 mid-LATCH, then release → latch/pulse/valid/busy=0 and buttons=0x00 immediately. No activity until poll_req.
- Single read, A+Start: pad model drives the active-low serial 0,1,1,0,1,1,1,1 (bits 0..7). Pulse poll_req → the following are all required:
  - nes_latch high for exactly 8 cycles.
  - 7 nes_pulse rising edges, each high 4 cycles.
  - valid in cycle 69 only.
  - buttons=0x09, pressed=0x09, released=0x00.
- Edge masks: after the previous case, pad returns A+Right (0x81) → buttons=0x81, pressed=0x80, released=0x08. Both masks are 0 the next cycle.
- Busy ignore / back-to-back:
  - poll_req pulsed at cycles 10 and 40 → exactly one valid.
  - poll_req held high → a second latch rises in cycle 70, and valid recurs every 69 cycles.
- Disconnected pad: nes_data tied 1 → buttons=0x00. If the prior buttons value was 0xFF, released=0xFF.
- Mid-read reset: assert reset during bit-5 PULSE_HI → all outputs 0 asynchronously, with no valid pulse. After release plus poll_req, a normal read of 0x10 (Up) yields buttons=0x10, pressed=0x10.
